dot_prod_engine: RTL and testbench

- Parametrised successor to the fixed-size dot-product kernel.
- Two on-chip operand arrays (a, b) are loaded and read by the host through a shared control port.
- On start, computes a reduction over a runtime index range [begin, end) in one of three modes: a·b, a·a, or Σa.
- Fully pipelined, one element per cycle, with optional saturating accumulation; sits beside the host bus as a compute leaf.

---
 rtl/dot_prod_pkg.sv | 49 ++++
 rtl/dp_ram.sv | 43 ++++
 rtl/dot_prod_engine.sv | 216 +++++++++++++++++++++
 tb/tb_dot_prod_engine.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dot_prod_pkg.sv
// Shared types and arithmetic helpers for the dot-product engine.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package dot_prod_pkg;

  // Widest accumulator the helper arithmetic supports. ACC_W must not exceed this.
  localparam int MAX_ACC_W = 128;
  localparam int ACC_IDX_W = $clog2(MAX_ACC_W);

  typedef enum logic [1:0] {
    MODE_DOT = 2'd0,
    MODE_SQ  = 2'd1,
    MODE_SUM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic                 ovf;
    logic [MAX_ACC_W-1:0] sum;
  } sat_res_t;

  // Add two values that are sign-extended from an (msb+1)-bit field. Overflow is
  // judged at that field width; with sat set, the sum clamps to the field's range.
  // The caller keeps only the low msb+1 bits of the sum.
  function automatic sat_res_t sat_add(
    input logic [MAX_ACC_W-1:0] acc,
    input logic [MAX_ACC_W-1:0] addend,
    input logic [ACC_IDX_W-1:0] msb,
    input logic                 sat
  );
    sat_res_t             res;
    logic [MAX_ACC_W-1:0] max_pos;
    max_pos = (MAX_ACC_W'(1) << msb) - MAX_ACC_W'(1);
    res.sum = acc + addend;
    res.ovf = (acc[msb] == addend[msb]) && (res.sum[msb] != acc[msb]);
    if (sat && res.ovf) begin
      // ~max_pos is the most negative value, already sign-extended
      res.sum = acc[msb] ? ~max_pos : max_pos;
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Single-port synchronous RAM holding one operand array.
// Latency: read data registered, valid the cycle after the address.
// Backpressure: none; a write cycle leaves the read register undefined (no read-through).
module dp_ram #(
  parameter int DATA_W = 27,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1000
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              in_range;

  assign in_range = ({1'b0, addr} < DEPTH_L);

  // Storage and registered read port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (in_range) begin
          mem[addr] <= wdata;
        end
        rdata_q <= 'x;
      end else if (in_range) begin
        rdata_q <= mem[addr];
      end else begin
        rdata_q <= 'x;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dot_prod_engine.sv
// Range reduction (a.b, a.a or sum a) over two host-loadable arrays, one element per cycle.
// Latency: (end-begin)+5 cycles from accepted start to w_enable; stalls add their length plus one replay cycle.
// Backpressure: controlArr high while busy freezes the engine and hands both arrays to the host.
module dot_prod_engine
  import dot_prod_pkg::*;
#(
  parameter int DATA_W = 27,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1000,
  parameter int ACC_W  = 64,
  parameter int SAT    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    r_enable,
  input  logic [ADDR_W-1:0]       init_begin,
  input  logic [ADDR_W-1:0]       init_end,
  input  logic signed [ACC_W-1:0] init_acc,
  input  logic [1:0]              mode,
  input  logic                    controlArr,
  input  logic                    controlArrWEnable_a,
  input  logic                    controlArrWEnable_b,
  input  logic [ADDR_W-1:0]       controlArrAddr_a,
  input  logic [ADDR_W-1:0]       controlArrAddr_b,
  input  logic [DATA_W-1:0]       controlArrWData_a,
  input  logic [DATA_W-1:0]       controlArrWData_b,
  output logic [DATA_W-1:0]       controlArrRData_a,
  output logic [DATA_W-1:0]       controlArrRData_b,
  output logic                    busy,
  output logic                    w_enable,
  output logic signed [ACC_W-1:0] result
);

  localparam int                    PROD_W  = 2 * DATA_W;
  localparam logic [ACC_IDX_W-1:0]  ACC_MSB = ACC_IDX_W'(ACC_W - 1);
  localparam logic                  SAT_L   = (SAT != 0);
  localparam logic [ADDR_W:0]       DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // Engine state
  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0]        end_q, end_d;
  mode_e                    mode_q, mode_d;
  // Pipeline: S1 (RAM data pending), S2 (product), S3 (accumulator)
  logic                     v1_q, v1_d;
  logic [ADDR_W-1:0]        addr1_q, addr1_d;
  logic                     v2_q, v2_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sat_hit_q, sat_hit_d;
  logic                     replay_q, replay_d;
  // Registered outputs
  logic                     busy_q, busy_d;
  logic                     wen_q, wen_d;
  logic signed [ACC_W-1:0]  result_q, result_d;

  logic                     stall;
  logic                     eng_en;
  logic [ADDR_W-1:0]        eng_addr;
  logic signed [DATA_W-1:0] rd_a, rd_b;
  sat_res_t                 add_res;
  logic                     unused_sum_bits;

  assign stall = busy_q && controlArr;

  // The accumulator add; bits above ACC_W are truncated away when stored.
  assign add_res         = sat_add(MAX_ACC_W'(acc_q), MAX_ACC_W'(prod_q), ACC_MSB, SAT_L);
  assign unused_sum_bits = ^add_res.sum;

  // Next-state logic: hold on stall, re-issue the lost read on replay, else advance the pipeline and FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    end_d     = end_q;
    mode_d    = mode_q;
    v1_d      = v1_q;
    addr1_d   = addr1_q;
    v2_d      = v2_q;
    prod_d    = prod_q;
    acc_d     = acc_q;
    sat_hit_d = sat_hit_q;
    busy_d    = busy_q;
    wen_d     = wen_q;
    result_d  = result_q;
    replay_d  = stall;
    eng_en    = 1'b0;
    eng_addr  = idx_q;

    if (!stall) begin
      if (replay_q) begin
        // The host overwrote the RAM output register; fetch the pending S1 word again.
        if (v1_q) begin
          eng_en   = 1'b1;
          eng_addr = addr1_q;
        end
      end else begin
        v2_d = v1_q;
        if (v1_q) begin
          case (mode_q)
            MODE_SQ:  prod_d = PROD_W'(rd_a) * PROD_W'(rd_a);
            MODE_SUM: prod_d = PROD_W'(rd_a);
            default:  prod_d = PROD_W'(rd_a) * PROD_W'(rd_b);
          endcase
        end
        // Once saturated the accumulator stays pinned for the rest of the run.
        if (v2_q && !sat_hit_q) begin
          acc_d     = ACC_W'(add_res.sum);
          sat_hit_d = SAT_L && add_res.ovf;
        end
        v1_d = 1'b0;

        case (state_q)
          IDLE: begin
            if (r_enable) begin
              idx_d     = init_begin;
              end_d     = init_end;
              acc_d     = init_acc;
              sat_hit_d = 1'b0;
              mode_d    = (mode == 2'd1) ? MODE_SQ : (mode == 2'd2) ? MODE_SUM : MODE_DOT;
              busy_d    = 1'b1;
              wen_d     = 1'b0;
              state_d   = (init_begin >= init_end) ? DONE : FETCH;
            end
          end
          FETCH: begin
            eng_en   = 1'b1;
            eng_addr = idx_q;
            v1_d     = 1'b1;
            addr1_d  = idx_q;
            idx_d    = idx_q + ADDR_W'(1);
            if (idx_q == end_q - ADDR_W'(1)) begin
              state_d = DRAIN;
            end
          end
          DRAIN: begin
            if (!v1_q && !v2_q) begin
              state_d = DONE;
            end
          end
          DONE: begin
            result_d = acc_q;
            wen_d    = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // FSM, pipeline and output registers; reset aborts any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      end_q     <= '0;
      mode_q    <= MODE_DOT;
      v1_q      <= 1'b0;
      addr1_q   <= '0;
      v2_q      <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
      sat_hit_q <= 1'b0;
      replay_q  <= 1'b0;
      busy_q    <= 1'b0;
      wen_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      end_q     <= end_d;
      mode_q    <= mode_d;
      v1_q      <= v1_d;
      addr1_q   <= addr1_d;
      v2_q      <= v2_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      sat_hit_q <= sat_hit_d;
      replay_q  <= replay_d;
      busy_q    <= busy_d;
      wen_q     <= wen_d;
      result_q  <= result_d;
    end
  end

  // Host owns both arrays while controlArr is high; otherwise the engine reads them.
  dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram_a (
    .clk   (clk),
    .en    (controlArr | eng_en),
    .we    (controlArr & controlArrWEnable_a),
    .addr  (controlArr ? controlArrAddr_a : eng_addr),
    .wdata (controlArrWData_a),
    .rdata (rd_a)
  );

  dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram_b (
    .clk   (clk),
    .en    (controlArr | eng_en),
    .we    (controlArr & controlArrWEnable_b),
    .addr  (controlArr ? controlArrAddr_b : eng_addr),
    .wdata (controlArrWData_b),
    .rdata (rd_b)
  );

  assign controlArrRData_a = rd_a;
  assign controlArrRData_b = rd_b;
  assign busy              = busy_q;
  assign w_enable          = wen_q;
  assign result            = result_q;

  // A non-empty range ending past the array would read undefined words.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE && r_enable && init_begin < init_end) |-> ({1'b0, init_end} <= DEPTH_L));

endmodule

// File: tb/tb_dot_prod_engine.sv
// Directed bench for dot_prod_engine: two instances (wrap and saturating) share all inputs.
// Latency: checks start-to-w_enable cycle counts against hand-computed values.
// Backpressure: exercises a host stall in the middle of a fetch.
module tb_dot_prod_engine;

  logic               clk = 1'b0;
  logic               rst;
  logic               r_enable;
  logic [9:0]         init_begin, init_end;
  logic signed [63:0] init_acc;
  logic [1:0]         mode;
  logic               controlArr;
  logic               cwe_a, cwe_b;
  logic [9:0]         caddr_a, caddr_b;
  logic [26:0]        cwd_a, cwd_b;

  logic [26:0]        rd_a, rd_b, s_rd_a, s_rd_b;
  logic               busy, w_enable, s_busy, s_w_enable;
  logic signed [63:0] result, s_result;

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  dot_prod_engine #(.DATA_W(27), .ADDR_W(10), .DEPTH(1000), .ACC_W(64), .SAT(0)) dut (
    .clk(clk), .rst(rst), .r_enable(r_enable), .init_begin(init_begin), .init_end(init_end),
    .init_acc(init_acc), .mode(mode), .controlArr(controlArr),
    .controlArrWEnable_a(cwe_a), .controlArrWEnable_b(cwe_b),
    .controlArrAddr_a(caddr_a), .controlArrAddr_b(caddr_b),
    .controlArrWData_a(cwd_a), .controlArrWData_b(cwd_b),
    .controlArrRData_a(rd_a), .controlArrRData_b(rd_b),
    .busy(busy), .w_enable(w_enable), .result(result)
  );

  dot_prod_engine #(.DATA_W(27), .ADDR_W(10), .DEPTH(1000), .ACC_W(64), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .r_enable(r_enable), .init_begin(init_begin), .init_end(init_end),
    .init_acc(init_acc), .mode(mode), .controlArr(controlArr),
    .controlArrWEnable_a(cwe_a), .controlArrWEnable_b(cwe_b),
    .controlArrAddr_a(caddr_a), .controlArrAddr_b(caddr_b),
    .controlArrWData_a(cwd_a), .controlArrWData_b(cwd_b),
    .controlArrRData_a(s_rd_a), .controlArrRData_b(s_rd_b),
    .busy(s_busy), .w_enable(s_w_enable), .result(s_result)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [9:0] b, input logic [9:0] e, input logic signed [63:0] acc,
                       input logic [1:0] m);
    init_begin = b;
    init_end   = e;
    init_acc   = acc;
    mode       = m;
    r_enable   = 1'b1;
    tick();
    r_enable   = 1'b0;
    lat        = 1;
  endtask

  task automatic wait_done;
    while (!w_enable && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    rst = 1'b1; r_enable = 1'b0; init_begin = '0; init_end = '0; init_acc = '0; mode = '0;
    controlArr = 1'b0; cwe_a = 1'b0; cwe_b = 1'b0; caddr_a = '0; caddr_b = '0; cwd_a = '0; cwd_b = '0;
    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_w_enable", w_enable, 0);
    check("reset_result", result, 0);
    rst = 1'b0;
    tick();

    // Load a[i]=i+1, b[i]=2
    controlArr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      caddr_a = 10'(i); caddr_b = 10'(i);
      cwd_a = 27'(i + 1); cwd_b = 27'd2;
      cwe_a = 1'b1; cwe_b = 1'b1;
      tick();
    end
    cwe_a = 1'b0; cwe_b = 1'b0;
    caddr_a = 10'd2; caddr_b = 10'd7;
    tick();
    check("idle_read_a2", rd_a, 3);
    check("idle_read_b7", rd_b, 2);
    check("idle_read_sat_a2", s_rd_a, 3);
    controlArr = 1'b0;
    tick();

    // a.b over [0,10)
    start(10'd0, 10'd10, 64'sd5, 2'd0);
    check("dot_busy", busy, 1);
    wait_done();
    check("dot_latency", lat, 15);
    check("dot_result", result, 115);
    check("dot_result_sat", s_result, 115);
    check("dot_busy_end", busy, 0);
    tick(); tick(); tick();
    check("dot_w_enable_sticky", w_enable, 1);

    start(10'd0, 10'd10, 64'sd5, 2'd1);
    wait_done();
    check("sq_result", result, 390);

    start(10'd0, 10'd10, 64'sd5, 2'd2);
    wait_done();
    check("sum_result", result, 60);

    start(10'd0, 10'd10, 64'sd5, 2'd3);
    wait_done();
    check("rsvd_mode_result", result, 115);

    // Empty range
    start(10'd4, 10'd4, -64'sd7, 2'd0);
    wait_done();
    check("empty_latency", lat, 2);
    check("empty_result", result, -7);

    // Host stall for 3 cycles mid-fetch, reading a[2]
    start(10'd0, 10'd10, 64'sd5, 2'd0);
    while (lat < 4) begin
      tick();
      lat++;
    end
    check("stall_pre_busy", busy, 1);
    controlArr = 1'b1; caddr_a = 10'd2;
    tick(); lat++;
    check("stall_read_a2", rd_a, 3);
    tick(); lat++;
    tick(); lat++;
    controlArr = 1'b0;
    wait_done();
    check("stall_latency", lat, 19);
    check("stall_result", result, 115);

    // Reset mid-fetch, then restart with an ignored start pulse while busy
    start(10'd0, 10'd10, 64'sd5, 2'd0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_w_enable", w_enable, 0);
    check("midrst_result", result, 0);
    tick();
    rst = 1'b0;
    tick();
    start(10'd0, 10'd10, 64'sd5, 2'd0);
    tick(); lat++;
    tick(); lat++;
    init_begin = 10'd3; init_end = 10'd5; init_acc = 64'sd1000; mode = 2'd2;
    r_enable = 1'b1;
    tick(); lat++;
    r_enable = 1'b0;
    wait_done();
    check("restart_latency", lat, 15);
    check("restart_result", result, 115);

    // Overflow on a single element: saturating vs wrapping instance
    controlArr = 1'b1;
    caddr_a = 10'd0; caddr_b = 10'd0;
    cwd_a = 27'h3FF_FFFF; cwd_b = 27'h3FF_FFFF;
    cwe_a = 1'b1; cwe_b = 1'b1;
    tick();
    cwe_a = 1'b0; cwe_b = 1'b0; controlArr = 1'b0;
    tick();
    start(10'd0, 10'd1, 64'sh7FFF_FFFF_FFFF_FFF6, 2'd0);
    wait_done();
    check("ovf_latency", lat, 6);
    check("ovf_sat_w_enable", s_w_enable, 1);
    check("ovf_sat_result", s_result, 64'sh7FFF_FFFF_FFFF_FFFF);
    check("ovf_wrap_result", result, 64'sh800F_FFFF_F7FF_FFF7);
    check("ovf_sat_busy", s_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
